// File: rtl/n64_pi_host_pkg.sv
// Shared constants for the N64 PI initiator: phase-length defaults, FSM encodings, helpers.
package n64_pi_host_pkg;

  localparam int unsigned T_ALE_DEFAULT         = 4;
  localparam int unsigned T_STROBE_LOW_DEFAULT  = 8;
  localparam int unsigned T_STROBE_HIGH_DEFAULT = 4;

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
  localparam logic [STATE_W-1:0] ST_ADDR_HIGH   = 3'd1;
  localparam logic [STATE_W-1:0] ST_ADDR_HOLD   = 3'd2;
  localparam logic [STATE_W-1:0] ST_ADDR_LOW    = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAP         = 3'd4;
  localparam logic [STATE_W-1:0] ST_STROBE_LOW  = 3'd5;
  localparam logic [STATE_W-1:0] ST_STROBE_HIGH = 3'd6;

  typedef logic [15:0] halfword_t;
  typedef logic [31:0] pi_addr_t;

  // The timer counts down to zero inclusive, so an N-cycle phase loads N-1.
  function automatic logic [TIMER_W-1:0] phase_load(input int unsigned cycles);
    return TIMER_W'(cycles - 1);
  endfunction

  function automatic logic is_page_end(input logic [8:0] addr_low);
    return addr_low == 9'h1FE;
  endfunction

  function automatic logic in_addr_phase(input logic [STATE_W-1:0] st);
    return (st == ST_ADDR_HIGH) || (st == ST_ADDR_HOLD) || (st == ST_ADDR_LOW);
  endfunction

  function automatic logic in_data_phase(input logic [STATE_W-1:0] st);
    return (st == ST_GAP) || (st == ST_STROBE_LOW) || (st == ST_STROBE_HIGH);
  endfunction

endpackage

// File: rtl/n64_pi_host_if.sv
// Request/data handshake plus PI pin bundle between the PI initiator and its user/target.
interface n64_pi_host_if
  import n64_pi_host_pkg::*;
();
  logic      i_request;
  logic      i_write;
  pi_addr_t  i_address;
  logic [7:0] i_length;
  logic      o_busy;
  logic      o_done;
  logic      o_wdata_ready;
  halfword_t i_wdata;
  halfword_t o_rdata;
  logic      o_rdata_valid;
  logic      o_n64_pi_aleh;
  logic      o_n64_pi_alel;
  logic      o_n64_pi_read;
  logic      o_n64_pi_write;
  halfword_t o_n64_pi_ad_out;
  logic      o_n64_pi_ad_oe;
  halfword_t i_n64_pi_ad;

  modport master (
    input  i_request, i_write, i_address, i_length, i_wdata, i_n64_pi_ad,
    output o_busy, o_done, o_wdata_ready, o_rdata, o_rdata_valid,
    output o_n64_pi_aleh, o_n64_pi_alel, o_n64_pi_read, o_n64_pi_write,
    output o_n64_pi_ad_out, o_n64_pi_ad_oe
  );

  modport slave (
    output i_request, i_write, i_address, i_length, i_wdata, i_n64_pi_ad,
    input  o_busy, o_done, o_wdata_ready, o_rdata, o_rdata_valid,
    input  o_n64_pi_aleh, o_n64_pi_alel, o_n64_pi_read, o_n64_pi_write,
    input  o_n64_pi_ad_out, o_n64_pi_ad_oe
  );
endinterface

// File: rtl/n64_pi_host_timer.sv
// Loadable down-counter that parks at zero; o_zero marks the last cycle of a phase.
module n64_pi_host_timer
  import n64_pi_host_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);
endmodule

// File: rtl/n64_pi_host.sv
// N64 PI bus initiator: address phase then READ/WRITE strobes per halfword of a burst.
// Define N64_PI_HOST_PAGE_SPLIT_EN to re-address after crossing each 512-byte page.
module n64_pi_host
  import n64_pi_host_pkg::*;
#(
  parameter int unsigned T_ALE         = T_ALE_DEFAULT,
  parameter int unsigned T_STROBE_LOW  = T_STROBE_LOW_DEFAULT,
  parameter int unsigned T_STROBE_HIGH = T_STROBE_HIGH_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_reset,
  n64_pi_host_if.master bus
);
  logic [STATE_W-1:0] state_q, state_d;
  logic               write_q, write_d;
  pi_addr_t           addr_q, addr_d;
  logic [7:0]         remain_q, remain_d;
  halfword_t          ad_out_q, ad_out_d;
  halfword_t          rdata_q, rdata_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic               done_q, done_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;

  pi_addr_t           addr_next;
  logic               last_hw;
  logic               resplit;
  logic               wdata_take;

  n64_pi_host_timer #(
    .W (TIMER_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (timer_load),
    .i_value (timer_value),
    .o_zero  (timer_zero)
  );

  assign addr_next = addr_q + 32'd2;
  assign last_hw   = (remain_q == 8'd0);

`ifdef N64_PI_HOST_PAGE_SPLIT_EN
  assign resplit = is_page_end(addr_q[8:0]) && !last_hw;
`else
  assign resplit = 1'b0;
`endif

  // Write data is fetched in the final cycle before every STROBE_LOW entry.
  assign wdata_take = write_q && timer_zero &&
                      ((state_q == ST_GAP) ||
                       ((state_q == ST_STROBE_HIGH) && !last_hw && !resplit));

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    ad_out_d      = ad_out_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    timer_load    = 1'b0;
    timer_value   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_request) begin
          state_d     = ST_ADDR_HIGH;
          write_d     = bus.i_write;
          addr_d      = bus.i_address & ~32'd1;
          remain_d    = bus.i_length;
          ad_out_d    = bus.i_address[31:16];
          timer_load  = 1'b1;
          timer_value = phase_load(T_ALE);
        end
      end
      ST_ADDR_HIGH: begin
        if (timer_zero) begin
          state_d     = ST_ADDR_HOLD;
          timer_load  = 1'b1;
          timer_value = phase_load(T_ALE);
        end
      end
      ST_ADDR_HOLD: begin
        if (timer_zero) begin
          state_d     = ST_ADDR_LOW;
          ad_out_d    = addr_q[15:0];
          timer_load  = 1'b1;
          timer_value = phase_load(T_ALE);
        end
      end
      ST_ADDR_LOW: begin
        if (timer_zero) begin
          state_d     = ST_GAP;
          timer_load  = 1'b1;
          timer_value = phase_load(T_ALE);
        end
      end
      ST_GAP: begin
        if (timer_zero) begin
          state_d     = ST_STROBE_LOW;
          timer_load  = 1'b1;
          timer_value = phase_load(T_STROBE_LOW);
          if (write_q) begin
            ad_out_d = bus.i_wdata;
          end
        end
      end
      ST_STROBE_LOW: begin
        if (timer_zero) begin
          state_d     = ST_STROBE_HIGH;
          timer_load  = 1'b1;
          timer_value = phase_load(T_STROBE_HIGH);
          if (!write_q) begin
            rdata_d       = bus.i_n64_pi_ad;
            rdata_valid_d = 1'b1;
          end
        end
      end
      ST_STROBE_HIGH: begin
        if (timer_zero) begin
          if (last_hw) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            ad_out_d = '0;
          end else begin
            remain_d   = remain_q - 8'd1;
            addr_d     = addr_next;
            timer_load = 1'b1;
            if (resplit) begin
              state_d     = ST_ADDR_HIGH;
              ad_out_d    = addr_next[31:16];
              timer_value = phase_load(T_ALE);
            end else begin
              state_d     = ST_STROBE_LOW;
              timer_value = phase_load(T_STROBE_LOW);
              if (write_q) begin
                ad_out_d = bus.i_wdata;
              end
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      remain_q      <= '0;
      ad_out_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      ad_out_q      <= ad_out_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
    end
  end

  // Pin outputs decode from reset-cleared registers, so reset idles the bus immediately.
  assign bus.o_n64_pi_aleh   = (state_q == ST_ADDR_HIGH);
  assign bus.o_n64_pi_alel   = in_addr_phase(state_q);
  assign bus.o_n64_pi_read   = ~((state_q == ST_STROBE_LOW) & ~write_q);
  assign bus.o_n64_pi_write  = ~((state_q == ST_STROBE_LOW) & write_q);
  assign bus.o_n64_pi_ad_oe  = in_addr_phase(state_q) | (write_q & in_data_phase(state_q));
  assign bus.o_n64_pi_ad_out = ad_out_q;
  assign bus.o_busy          = (state_q != ST_IDLE);
  assign bus.o_done          = done_q;
  assign bus.o_wdata_ready   = wdata_take;
  assign bus.o_rdata         = rdata_q;
  assign bus.o_rdata_valid   = rdata_valid_q;
endmodule
